// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the RegisterFile write port between ALU (A) and load (M) writebacks, each with a 1-entry hold.
// Latency: accept -> write next cycle at the earliest. Optional macro RR_ARB_EN selects round-robin conflicts.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  localparam int NREGS = 2**REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_W-1:0]  a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [REG_W-1:0]  m_reg,
  input  logic [DATA_W-1:0] m_data,
  output logic              wr_en,
  output logic [REG_W-1:0]  wr_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic [NREGS-1:0]  pending,
  input  logic [REG_W-1:0]  chk_reg1,
  input  logic [REG_W-1:0]  chk_reg2,
  output logic              hazard1,
  output logic              hazard2
);

  logic              hv_a, hv_m;
  logic [REG_W-1:0]  hreg_a, hreg_m;
  logic [DATA_W-1:0] hdata_a, hdata_m;
  logic              m_older;
  logic              grant_a, grant_m;
  logic              load_a, load_m;
  logic              conflict;

  assign conflict = hv_a && hv_m && (hreg_a != hreg_m);

`ifdef RR_ARB_EN
  logic rr_m;

  always_ff @(posedge clk) begin
    if (!rst) rr_m <= 1'b0;
    else if (conflict) rr_m <= ~rr_m;
  end
`endif

  // Grant depends only on hold state, so a new request can never issue in its accept cycle.
  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (rst) begin
      if (hv_a && hv_m) begin
        if (!conflict) begin
          grant_m = m_older;
          grant_a = ~m_older;
        end else begin
`ifdef RR_ARB_EN
          grant_m = rr_m;
          grant_a = ~rr_m;
`else
          grant_m = 1'b1;
`endif
        end
      end else begin
        grant_a = hv_a;
        grant_m = hv_m;
      end
    end
  end

  assign a_ready = rst & (~hv_a | grant_a);
  assign m_ready = rst & (~hv_m | grant_m);
  assign load_a  = a_valid & a_ready & (a_reg != '0);
  assign load_m  = m_valid & m_ready & (m_reg != '0);

  assign wr_en   = grant_a | grant_m;
  assign wr_reg  = grant_a ? hreg_a  : (grant_m ? hreg_m  : '0);
  assign wr_data = grant_a ? hdata_a : (grant_m ? hdata_m : '0);

  always_comb begin
    pending = '0;
    if (rst) begin
      if (hv_a) pending[hreg_a] = 1'b1;
      if (hv_m) pending[hreg_m] = 1'b1;
    end
  end

  assign hazard1 = rst && (chk_reg1 != '0) &&
                   ((hv_a && !grant_a && (hreg_a == chk_reg1)) ||
                    (hv_m && !grant_m && (hreg_m == chk_reg1)));
  assign hazard2 = rst && (chk_reg2 != '0) &&
                   ((hv_a && !grant_a && (hreg_a == chk_reg2)) ||
                    (hv_m && !grant_m && (hreg_m == chk_reg2)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      hv_a    <= 1'b0;
      hv_m    <= 1'b0;
      hreg_a  <= '0;
      hreg_m  <= '0;
      hdata_a <= '0;
      hdata_m <= '0;
      m_older <= 1'b0;
    end else begin
      if (load_a) begin
        hv_a    <= 1'b1;
        hreg_a  <= a_reg;
        hdata_a <= a_data;
      end else if (grant_a) begin
        hv_a <= 1'b0;
      end
      if (load_m) begin
        hv_m    <= 1'b1;
        hreg_m  <= m_reg;
        hdata_m <= m_data;
      end else if (grant_m) begin
        hv_m <= 1'b0;
      end
      // The hold that survives this edge unissued is older than a freshly loaded one.
      if (load_a && load_m) m_older <= 1'b1;
      else if (load_a)      m_older <= hv_m & ~grant_m;
      else if (load_m)      m_older <= ~(hv_a & ~grant_a);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, an arbitration sequence, then random traffic vs a model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid, m_valid;
  logic        a_ready, m_ready;
  logic [3:0]  a_reg, m_reg;
  logic [15:0] a_data, m_data;
  logic        wr_en;
  logic [3:0]  wr_reg;
  logic [15:0] wr_data;
  logic [15:0] pending;
  logic [3:0]  chk_reg1, chk_reg2;
  logic        hazard1, hazard2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] rf_obs [16];
  logic [15:0] rf_mod [16];

  regfile_wb_arbiter #(.DATA_W(16), .REG_W(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_reg(m_reg), .m_data(m_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .pending(pending),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .hazard1(hazard1), .hazard2(hazard2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        rst;
    logic        av;
    logic [3:0]  ar;
    logic [15:0] ad;
    logic        mv;
    logic [3:0]  mr;
    logic [15:0] md;
    logic [3:0]  c1;
    logic [3:0]  c2;
    logic        ea;
    logic        em;
    logic        ewe;
    logic [3:0]  ereg;
    logic [15:0] edat;
    logic [15:0] epend;
    logic        eh1;
    logic        eh2;
  } vec_t;

  function automatic vec_t mk(logic r, logic av, logic [3:0] ar, logic [15:0] ad,
                              logic mv, logic [3:0] mr, logic [15:0] md,
                              logic [3:0] c1, logic [3:0] c2,
                              logic ea, logic em, logic ewe, logic [3:0] ereg,
                              logic [15:0] edat, logic [15:0] epend, logic eh1, logic eh2);
    vec_t v;
    v.rst = r;   v.av = av;   v.ar = ar;     v.ad = ad;
    v.mv = mv;   v.mr = mr;   v.md = md;     v.c1 = c1;   v.c2 = c2;
    v.ea = ea;   v.em = em;   v.ewe = ewe;   v.ereg = ereg;
    v.edat = edat; v.epend = epend; v.eh1 = eh1; v.eh2 = eh2;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.rst; a_valid = v.av; a_reg = v.ar; a_data = v.ad;
    m_valid = v.mv; m_reg = v.mr; m_data = v.md;
    chk_reg1 = v.c1; chk_reg2 = v.c2;
  endtask

  task automatic check_outs(string tag, vec_t v);
    chk({tag, ".a_ready"}, 32'(a_ready), 32'(v.ea));
    chk({tag, ".m_ready"}, 32'(m_ready), 32'(v.em));
    chk({tag, ".wr_en"},   32'(wr_en),   32'(v.ewe));
    chk({tag, ".wr_reg"},  32'(wr_reg),  32'(v.ereg));
    chk({tag, ".wr_data"}, 32'(wr_data), 32'(v.edat));
    chk({tag, ".pending"}, 32'(pending), 32'(v.epend));
    chk({tag, ".hazard1"}, 32'(hazard1), 32'(v.eh1));
    chk({tag, ".hazard2"}, 32'(hazard2), 32'(v.eh2));
  endtask

  // One cycle: drive, sample mid-cycle, log the observed write, advance past the edge.
  task automatic apply(string tag, vec_t v);
    drive(v);
    #1;
    check_outs(tag, v);
    if (wr_en) rf_obs[wr_reg] = wr_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: holds tagged with an accept sequence number; lower number = older.
  bit          ma_v, mm_v;
  logic [3:0]  ma_r, mm_r;
  logic [15:0] ma_d, mm_d;
  int          ma_s, mm_s, seq_ctr;
  bit          last_win_m;

  task automatic rstep(int cyc, bit force_rst);
    vec_t v;
    bit ga, gm;
    v = '0;
    v.rst = force_rst ? 1'b0 : ($urandom_range(0, 49) != 0);
    v.av  = ($urandom_range(0, 2) != 0);
    v.ar  = 4'($urandom_range(0, 3));
    v.ad  = 16'($urandom);
    v.mv  = ($urandom_range(0, 2) != 0);
    v.mr  = 4'($urandom_range(0, 3));
    v.md  = 16'($urandom);
    v.c1  = 4'($urandom_range(0, 3));
    v.c2  = 4'($urandom_range(0, 3));
    ga = 0;
    gm = 0;
    if (v.rst) begin
      if (ma_v && mm_v) begin
        if (ma_r == mm_r) begin
          if (mm_s < ma_s) gm = 1; else ga = 1;
        end else begin
`ifdef RR_ARB_EN
          if (last_win_m) ga = 1; else gm = 1;
`else
          gm = 1;
`endif
        end
      end else begin
        ga = ma_v;
        gm = mm_v;
      end
    end
    v.ea   = v.rst && (!ma_v || ga);
    v.em   = v.rst && (!mm_v || gm);
    v.ewe  = ga || gm;
    v.ereg = ga ? ma_r : (gm ? mm_r : 4'd0);
    v.edat = ga ? ma_d : (gm ? mm_d : 16'd0);
    v.epend = '0;
    if (v.rst && ma_v) v.epend[ma_r] = 1'b1;
    if (v.rst && mm_v) v.epend[mm_r] = 1'b1;
    v.eh1 = v.rst && (v.c1 != 0) &&
            ((ma_v && !ga && ma_r == v.c1) || (mm_v && !gm && mm_r == v.c1));
    v.eh2 = v.rst && (v.c2 != 0) &&
            ((ma_v && !ga && ma_r == v.c2) || (mm_v && !gm && mm_r == v.c2));
    drive(v);
    #1;
    check_outs($sformatf("rnd%0d", cyc), v);
    if (wr_en) rf_obs[wr_reg] = wr_data;
    if (v.ewe) rf_mod[v.ereg] = v.edat;
    @(posedge clk);
    if (!v.rst) begin
      ma_v = 0;
      mm_v = 0;
      last_win_m = 1;
    end else begin
      if (ma_v && mm_v && ma_r != mm_r) last_win_m = gm;
      if (ga) ma_v = 0;
      if (gm) mm_v = 0;
      if (v.mv && v.em && v.mr != 0) begin
        mm_v = 1; mm_r = v.mr; mm_d = v.md; mm_s = seq_ctr; seq_ctr++;
      end
      if (v.av && v.ea && v.ar != 0) begin
        ma_v = 1; ma_r = v.ar; ma_d = v.ad; ma_s = seq_ctr; seq_ctr++;
      end
    end
    @(negedge clk);
  endtask

  vec_t tbl [16];

  initial begin
    vec_t v;
    for (int i = 0; i < 16; i++) begin
      rf_obs[i] = '0;
      rf_mod[i] = '0;
    end
    ma_v = 0; mm_v = 0; ma_r = 0; mm_r = 0; ma_d = 0; mm_d = 0;
    ma_s = 0; mm_s = 0; seq_ctr = 0; last_win_m = 1;

    //            rst av ar ad       mv mr md       c1 c2  ea em we reg dat      pend     h1 h2
    tbl[0]  = mk(0, 1, 3, 16'h1111, 1, 4, 16'h2222, 3, 4,  0, 0, 0, 0, 16'h0,    16'h0,   0, 0);
    tbl[1]  = mk(0, 1, 3, 16'h1111, 1, 4, 16'h2222, 3, 4,  0, 0, 0, 0, 16'h0,    16'h0,   0, 0);
    tbl[2]  = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    3, 4,  1, 1, 0, 0, 16'h0,    16'h0,   0, 0);
    tbl[3]  = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    3, 4,  1, 1, 0, 0, 16'h0,    16'h0,   0, 0);
    tbl[4]  = mk(1, 1, 5, 16'h1234, 0, 0, 16'h0,    5, 0,  1, 1, 0, 0, 16'h0,    16'h0,   0, 0);
    tbl[5]  = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    5, 0,  1, 1, 1, 5, 16'h1234, 16'h0020, 0, 0);
    tbl[6]  = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    5, 0,  1, 1, 0, 0, 16'h0,    16'h0,   0, 0);
    tbl[7]  = mk(1, 1, 0, 16'hFFFF, 0, 0, 16'h0,    0, 0,  1, 1, 0, 0, 16'h0,    16'h0,   0, 0);
    tbl[8]  = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0,  1, 1, 0, 0, 16'h0,    16'h0,   0, 0);
    tbl[9]  = mk(1, 1, 7, 16'h1111, 1, 7, 16'h2222, 7, 0,  1, 1, 0, 0, 16'h0,    16'h0,   0, 0);
    tbl[10] = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    7, 7,  0, 1, 1, 7, 16'h2222, 16'h0080, 1, 1);
    tbl[11] = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    7, 0,  1, 1, 1, 7, 16'h1111, 16'h0080, 0, 0);
    tbl[12] = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    7, 0,  1, 1, 0, 0, 16'h0,    16'h0,   0, 0);
    tbl[13] = mk(1, 0, 0, 16'h0,    1, 9, 16'h00FF, 9, 0,  1, 1, 0, 0, 16'h0,    16'h0,   0, 0);
    tbl[14] = mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    9, 0,  0, 0, 0, 0, 16'h0,    16'h0,   0, 0);
    tbl[15] = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    9, 0,  1, 1, 0, 0, 16'h0,    16'h0,   0, 0);

    for (int i = 0; i < 16; i++) apply($sformatf("vec%0d", i), tbl[i]);

    chk("rf_r5",  32'(rf_obs[5]), 32'h1234);
    chk("rf_r7",  32'(rf_obs[7]), 32'h1111);
    chk("rf_r9",  32'(rf_obs[9]), 32'h0000);
    chk("rf_r0",  32'(rf_obs[0]), 32'h0000);

    // Both requesters stream continuously to different registers.
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        v = mk(1, 1, 3, 16'hAAAA, 1, 4, 16'hBBBB, 3, 4, 1, 1, 0, 0, 16'h0, 16'h0, 0, 0);
      end else begin
`ifdef RR_ARB_EN
        if (k % 2 == 1)
          v = mk(1, 1, 3, 16'hAAAA, 1, 4, 16'hBBBB, 3, 4, 1, 0, 1, 3, 16'hAAAA, 16'h0018, 0, 1);
        else
          v = mk(1, 1, 3, 16'hAAAA, 1, 4, 16'hBBBB, 3, 4, 0, 1, 1, 4, 16'hBBBB, 16'h0018, 1, 0);
`else
        v = mk(1, 1, 3, 16'hAAAA, 1, 4, 16'hBBBB, 3, 4, 0, 1, 1, 4, 16'hBBBB, 16'h0018, 1, 0);
`endif
      end
      apply($sformatf("conf%0d", k), v);
    end
    apply("conf_rst", mk(0, 0, 0, 16'h0, 0, 0, 16'h0, 3, 4, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0));

    for (int i = 0; i < 16; i++) begin
      rf_obs[i] = '0;
      rf_mod[i] = '0;
    end
    rstep(0, 1'b1);
    for (int c = 1; c < 600; c++) rstep(c, 1'b0);
    for (int i = 0; i < 16; i++) chk($sformatf("rf_final_r%0d", i), 32'(rf_obs[i]), 32'(rf_mod[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
